dht11_read_sequencer: RTL and testbench

Controller that sequences the DHT11 driver (drives its EN/RST, monitors WAIT/error/CRC) and serves read requests from the command/UART side over a valid/ready handshake. It enforces the sensor's minimum inter-read interval, retries failed reads, and answers requests from a cache while a fresh read is not allowed. It replaces the ad-hoc start/main FSM mux on the driver's EN/RST.

---
 rtl/dht11_read_sequencer_if.sv | 46 ++++
 rtl/dht11_read_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_dht11_read_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dht11_read_sequencer_if.sv
// ---------------------------------------------------------------------------
// dht11_read_sequencer_if
//
// Request/response bundle between the command/UART side and the DHT11 read
// sequencer.
//
//   req_valid  : request present (requester -> sequencer)
//   req_ready  : sequencer can take a request; accept = req_valid & req_ready
//   req_sel    : 00 humidity, 01 temperature, 10 both integer bytes,
//                11 status-only (failure counter)
//   rsp_valid  : response present, held until rsp_ready
//   rsp_ready  : requester accepts the response
//   rsp_data   : response payload
//   rsp_status : 00 fresh, 01 cached, 10 sensor/CRC error, 11 timeout
//
// Modports: master = requester side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface dht11_read_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_status;

    modport master (
        output req_valid,
        output req_sel,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_status
    );

    modport slave (
        input  req_valid,
        input  req_sel,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_status
    );
endinterface

// File: rtl/dht11_read_sequencer.sv
// ---------------------------------------------------------------------------
// dht11_read_sequencer
//
// Owns the DHT11 driver's EN/RST lines and serves read requests arriving on a
// valid/ready bus. A fresh sensor read is only started when at least
// MIN_INTERVAL_CYC cycles have passed since the previous read start; inside
// that window requests are answered from a cache of the last good read, or
// held off until the window expires if no good read exists yet. Failed reads
// (driver error, bad checksum, or busy timeout) are retried up to MAX_RETRIES
// extra times, each retry also respecting the minimum interval.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   bus           request/response bundle (slave side)
//   dht_en_o      driver enable, high only while a transaction is in flight
//   dht_rst_o     driver reset, high whenever the driver is parked
//   dht_wait_i    driver busy flag
//   dht_error_i   driver error flag
//   dht_crc_i     driver checksum-valid flag
//   hum_int_i, hum_float_i, temp_int_i, temp_float_i : driver data bytes
//   busy_o        high in every state except IDLE
// ---------------------------------------------------------------------------
module dht11_read_sequencer #(
    parameter int unsigned MIN_INTERVAL_CYC = 200_000_000,
    parameter int unsigned RST_PULSE_CYC    = 100,
    parameter int unsigned BUSY_TIMEOUT_CYC = 5_000_000,
    parameter int unsigned MAX_RETRIES      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    dht11_read_sequencer_if.slave        bus,
    output logic                         dht_en_o,
    output logic                         dht_rst_o,
    input  logic                         dht_wait_i,
    input  logic                         dht_error_i,
    input  logic                         dht_crc_i,
    input  logic [7:0]                   hum_int_i,
    input  logic [7:0]                   hum_float_i,
    input  logic [7:0]                   temp_int_i,
    input  logic [7:0]                   temp_float_i,
    output logic                         busy_o
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    localparam int IVL_W = $clog2(MIN_INTERVAL_CYC + 1);
    localparam int TO_W  = $clog2(BUSY_TIMEOUT_CYC + 1);
    localparam int RP_W  = $clog2(RST_PULSE_CYC + 1);

    localparam logic [IVL_W-1:0] IVL_MAX    = IVL_W'(MIN_INTERVAL_CYC);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(BUSY_TIMEOUT_CYC - 1);
    localparam logic [RP_W-1:0]  PULSE_LAST = RP_W'(RST_PULSE_CYC - 1);
    localparam logic [2:0]       RETRY_MAX  = 3'(MAX_RETRIES);

    localparam logic [1:0] ST_FRESH   = 2'b00;
    localparam logic [1:0] ST_CACHED  = 2'b01;
    localparam logic [1:0] ST_ERROR   = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    // FSM encoding. DECIDE is the cycle after acceptance in which the latched
    // selector is routed; it gives the two-cycle accept-to-response latency
    // of the cached path and keeps REQ_READY a pure decode of IDLE.
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_DECIDE    = 4'd1;
    localparam logic [3:0] S_HOLDOFF   = 4'd2;
    localparam logic [3:0] S_RESET_DRV = 4'd3;
    localparam logic [3:0] S_ENABLE    = 4'd4;
    localparam logic [3:0] S_WAIT_DONE = 4'd5;
    localparam logic [3:0] S_CHECK     = 4'd6;
    localparam logic [3:0] S_FAIL      = 4'd7;
    localparam logic [3:0] S_RESPOND   = 4'd8;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]       state_q,       state_d;
    logic [1:0]       sel_q,         sel_d;
    logic [2:0]       retry_q,       retry_d;
    logic [IVL_W-1:0] ivl_q,         ivl_d;
    logic [TO_W-1:0]  to_q,          to_d;
    logic [RP_W-1:0]  pulse_q,       pulse_d;
    logic [7:0]       fail_cnt_q,    fail_cnt_d;
    logic [1:0]       cause_q,       cause_d;
    logic             seen_q,        seen_d;
    logic             err_q,         err_d;
    logic             cache_valid_q, cache_valid_d;
    logic [7:0]       c_hum_int_q,   c_hum_int_d;
    logic [7:0]       c_hum_frac_q,  c_hum_frac_d;
    logic [7:0]       c_temp_int_q,  c_temp_int_d;
    logic [7:0]       c_temp_frac_q, c_temp_frac_d;
    logic [15:0]      rsp_data_q,    rsp_data_d;
    logic [1:0]       rsp_status_q,  rsp_status_d;

    // Two-stage sample of the driver busy flag; the fall is detected between
    // the stages so it is a clean registered edge.
    logic             wait_s1_q;
    logic             wait_s2_q;

    logic             read_allowed;
    logic             wait_fall;
    logic             check_ok;

    assign read_allowed = (ivl_q == IVL_MAX);
    // Only a fall that follows an observed high counts as completion, so a
    // driver that never raised WAIT cannot end the transaction early.
    assign wait_fall    = seen_q & wait_s2_q & ~wait_s1_q;
    assign check_ok     = ~err_q & ~dht_error_i & dht_crc_i;

    // Payload selection shared by the fresh and cached paths.
    function automatic logic [15:0] pick(
        input logic [1:0] sel,
        input logic [7:0] hi,
        input logic [7:0] hf,
        input logic [7:0] ti,
        input logic [7:0] tf
    );
        logic [15:0] r;
        case (sel)
            2'b00:   r = {hi, hf};
            2'b01:   r = {ti, tf};
            default: r = {hi, ti};
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        retry_d       = retry_q;
        to_d          = to_q;
        pulse_d       = pulse_q;
        fail_cnt_d    = fail_cnt_q;
        cause_d       = cause_q;
        seen_d        = seen_q;
        err_d         = err_q;
        cache_valid_d = cache_valid_q;
        c_hum_int_d   = c_hum_int_q;
        c_hum_frac_d  = c_hum_frac_q;
        c_temp_int_d  = c_temp_int_q;
        c_temp_frac_d = c_temp_frac_q;
        rsp_data_d    = rsp_data_q;
        rsp_status_d  = rsp_status_q;
        ivl_d         = read_allowed ? ivl_q : ivl_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    sel_d   = bus.req_sel;
                    state_d = S_DECIDE;
                end
            end

            S_DECIDE: begin
                if (sel_q == 2'b11) begin
                    rsp_data_d   = {8'd0, fail_cnt_q};
                    rsp_status_d = ST_FRESH;
                    state_d      = S_RESPOND;
                end else if (read_allowed) begin
                    retry_d = 3'd0;
                    state_d = S_RESET_DRV;
                end else if (cache_valid_q) begin
                    rsp_data_d   = pick(sel_q, c_hum_int_q, c_hum_frac_q,
                                        c_temp_int_q, c_temp_frac_q);
                    rsp_status_d = ST_CACHED;
                    state_d      = S_RESPOND;
                end else begin
                    retry_d = 3'd0;
                    state_d = S_HOLDOFF;
                end
            end

            S_HOLDOFF: begin
                if (read_allowed) begin
                    state_d = S_RESET_DRV;
                end
            end

            S_RESET_DRV: begin
                if (pulse_q == PULSE_LAST) begin
                    state_d = S_ENABLE;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end

            S_ENABLE: begin
                // The ENABLE cycle is the first cycle of the busy budget.
                to_d    = TO_W'(1);
                seen_d  = 1'b0;
                err_d   = 1'b0;
                state_d = S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
                if (wait_s1_q) begin
                    seen_d = 1'b1;
                end
                to_d = to_q + 1'b1;
                // Error takes priority over a simultaneous WAIT fall or timeout.
                if (dht_error_i) begin
                    err_d   = 1'b1;
                    state_d = S_CHECK;
                end else if (wait_fall) begin
                    state_d = S_CHECK;
                end else if (to_q >= TO_LAST) begin
                    cause_d = ST_TIMEOUT;
                    state_d = S_FAIL;
                end
            end

            S_CHECK: begin
                if (check_ok) begin
                    c_hum_int_d   = hum_int_i;
                    c_hum_frac_d  = hum_float_i;
                    c_temp_int_d  = temp_int_i;
                    c_temp_frac_d = temp_float_i;
                    cache_valid_d = 1'b1;
                    rsp_data_d    = pick(sel_q, hum_int_i, hum_float_i,
                                         temp_int_i, temp_float_i);
                    rsp_status_d  = ST_FRESH;
                    state_d       = S_RESPOND;
                end else begin
                    cause_d = ST_ERROR;
                    state_d = S_FAIL;
                end
            end

            S_FAIL: begin
                if (fail_cnt_q != 8'hFF) begin
                    fail_cnt_d = fail_cnt_q + 8'd1;
                end
                if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 3'd1;
                    state_d = S_HOLDOFF;
                end else begin
                    // A failed read never touches the cache; the last good
                    // values are still the best answer available.
                    rsp_data_d   = cache_valid_q
                                 ? pick(sel_q, c_hum_int_q, c_hum_frac_q,
                                        c_temp_int_q, c_temp_frac_q)
                                 : 16'd0;
                    rsp_status_d = cause_q;
                    state_d      = S_RESPOND;
                end
            end

            S_RESPOND: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entering RESET_DRV marks a read start: restart the inter-read
        // interval and the reset pulse length.
        if ((state_d == S_RESET_DRV) && (state_q != S_RESET_DRV)) begin
            ivl_d   = '0;
            pulse_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sel_q         <= 2'b00;
            retry_q       <= 3'd0;
            ivl_q         <= IVL_MAX;  // first read allowed straight away
            to_q          <= '0;
            pulse_q       <= '0;
            fail_cnt_q    <= 8'd0;
            cause_q       <= ST_ERROR;
            seen_q        <= 1'b0;
            err_q         <= 1'b0;
            cache_valid_q <= 1'b0;
            c_hum_int_q   <= 8'd0;
            c_hum_frac_q  <= 8'd0;
            c_temp_int_q  <= 8'd0;
            c_temp_frac_q <= 8'd0;
            rsp_data_q    <= 16'd0;
            rsp_status_q  <= 2'b00;
            wait_s1_q     <= 1'b0;
            wait_s2_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            retry_q       <= retry_d;
            ivl_q         <= ivl_d;
            to_q          <= to_d;
            pulse_q       <= pulse_d;
            fail_cnt_q    <= fail_cnt_d;
            cause_q       <= cause_d;
            seen_q        <= seen_d;
            err_q         <= err_d;
            cache_valid_q <= cache_valid_d;
            c_hum_int_q   <= c_hum_int_d;
            c_hum_frac_q  <= c_hum_frac_d;
            c_temp_int_q  <= c_temp_int_d;
            c_temp_frac_q <= c_temp_frac_d;
            rsp_data_q    <= rsp_data_d;
            rsp_status_q  <= rsp_status_d;
            wait_s1_q     <= dht_wait_i;
            wait_s2_q     <= wait_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from the state register so reset parks the driver
    // in the same cycle it is asserted.
    // ------------------------------------------------------------------
    logic drv_active;
    assign drv_active     = (state_q == S_ENABLE) || (state_q == S_WAIT_DONE);

    assign dht_en_o       = drv_active;
    // RST is also released in CHECK so the driver's data bytes are not
    // disturbed while they are being captured.
    assign dht_rst_o      = ~(drv_active || (state_q == S_CHECK));
    assign busy_o         = (state_q != S_IDLE);

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.rsp_valid  = (state_q == S_RESPOND);
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_status = rsp_status_q;

endmodule

// File: tb/tb_dht11_read_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for dht11_read_sequencer with shortened timing parameters.
// A behavioural DHT11 driver model answers EN pulses; a cache/fail-count
// model predicts each response from the request rules.
// ---------------------------------------------------------------------------
module tb_dht11_read_sequencer;
    localparam int MIN_IV    = 1000;
    localparam int RST_PULSE = 4;
    localparam int TIMEOUT   = 500;
    localparam int RETRIES   = 2;
    localparam int LIMIT     = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dht_en, dht_rst, busy;
    logic       dht_wait = 1'b0, dht_error = 1'b0, dht_crc = 1'b1;
    logic [7:0] hum_int = 8'd0, hum_float = 8'd0, temp_int = 8'd0, temp_float = 8'd0;

    dht11_read_sequencer_if bus();

    dht11_read_sequencer #(
        .MIN_INTERVAL_CYC (MIN_IV),
        .RST_PULSE_CYC    (RST_PULSE),
        .BUSY_TIMEOUT_CYC (TIMEOUT),
        .MAX_RETRIES      (RETRIES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .dht_en_o     (dht_en),
        .dht_rst_o    (dht_rst),
        .dht_wait_i   (dht_wait),
        .dht_error_i  (dht_error),
        .dht_crc_i    (dht_crc),
        .hum_int_i    (hum_int),
        .hum_float_i  (hum_float),
        .temp_int_i   (temp_int),
        .temp_float_i (temp_float),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Driver model and EN activity log
    int   en_rises[$];
    int   en_widths[$];
    bit   drv_never_fall = 1'b0;
    bit   both_hi_seen = 1'b0;
    int   drv_cnt = 0;
    logic drv_en_prev = 1'b0;
    int   drv_rise = 0;

    // Reference model state
    logic [7:0] m_cache [4];
    bit         m_cache_valid = 1'b0;
    int         m_fail = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (dht_en && dht_rst) both_hi_seen = 1'b1;
            if (dht_en && !drv_en_prev) begin
                en_rises.push_back(cyc);
                drv_rise = cyc;
            end
            if (!dht_en && drv_en_prev) en_widths.push_back(cyc - drv_rise);
            drv_en_prev = dht_en;
            if (dht_en) drv_cnt++; else drv_cnt = 0;
            // WAIT high 10 cycles after enable, low again 50 cycles later
            dht_wait = (drv_cnt > 10) && (drv_never_fall || drv_cnt <= 60);
        end
    end

    function automatic logic [15:0] model_pick(input logic [1:0] sel, input logic [7:0] hi,
                                               input logic [7:0] hf, input logic [7:0] ti,
                                               input logic [7:0] tf);
        case (sel)
            2'd0:    return {hi, hf};
            2'd1:    return {ti, tf};
            2'd2:    return {hi, ti};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic new_sensor_values();
        hum_int    = 8'($urandom_range(20, 95));
        hum_float  = 8'($urandom_range(0, 9));
        temp_int   = 8'($urandom_range(0, 50));
        temp_float = 8'($urandom_range(0, 9));
    endtask

    task automatic model_store();
        m_cache[0] = hum_int; m_cache[1] = hum_float;
        m_cache[2] = temp_int; m_cache[3] = temp_float;
        m_cache_valid = 1'b1;
    endtask

    task automatic wait_allowed();
        int last;
        last = (en_rises.size() > 0) ? en_rises[$] : 0;
        while (cyc < last + MIN_IV + 50) @(negedge clk);
    endtask

    // One request/response transaction. rdy_delay < 0 holds RSP_READY high
    // from before the response appears.
    task automatic do_req(input logic [1:0] sel, input int rdy_delay,
                          output int acc_cyc, output int vld_cyc,
                          output logic [15:0] d, output logic [1:0] st,
                          output logic post_valid, output logic en_at_vld,
                          output bit timed_out);
        int n;
        timed_out = 1'b0;
        @(negedge clk);
        bus.req_sel   = sel;
        bus.req_valid = 1'b1;
        bus.rsp_ready = (rdy_delay < 0);
        n = 0;
        while (!bus.req_ready && n < LIMIT) begin @(negedge clk); n++; end
        if (n >= LIMIT) timed_out = 1'b1;
        acc_cyc = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < LIMIT) begin @(negedge clk); n++; end
        if (n >= LIMIT) timed_out = 1'b1;
        vld_cyc   = cyc;
        d         = bus.rsp_data;
        st        = bus.rsp_status;
        en_at_vld = dht_en;
        for (int i = 0; i < rdy_delay; i++) @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        post_valid    = bus.rsp_valid;
        bus.rsp_ready = 1'b0;
        $display("txn sel=%0d status=%0d data=%04h accept@%0d valid@%0d", sel, st, d, acc_cyc, vld_cyc);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        vectors++; if (bus.rsp_data !== 16'h0) begin miscompares++; $display("FAIL reset_rsp_data: got %h expected 0000", bus.rsp_data); end
        vectors++; if (bus.rsp_status !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_status: got %b expected 00", bus.rsp_status); end
        vectors++; if (dht_en !== 1'b0) begin miscompares++; $display("FAIL reset_dht_en: got %b expected 0", dht_en); end
        vectors++; if (dht_rst !== 1'b1) begin miscompares++; $display("FAIL reset_dht_rst: got %b expected 1", dht_rst); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_fresh_read();
        int acc, vld, base; logic [15:0] d; logic [1:0] st; logic pv, env; bit to;
        hum_int = 8'd45; hum_float = 8'd0;
        temp_int = 8'($urandom_range(0, 50)); temp_float = 8'($urandom_range(0, 9));
        base = en_rises.size();
        do_req(2'd0, 0, acc, vld, d, st, pv, env, to);
        vectors++; if (to) begin miscompares++; $display("FAIL fresh_done: got timeout expected response"); end
        vectors++; if (en_rises.size() - base !== 1) begin miscompares++; $display("FAIL fresh_en_pulses: got %0d expected 1", en_rises.size() - base); end
        if (en_rises.size() > base) begin
            vectors++; if (en_rises[base] - acc !== RST_PULSE + 2) begin miscompares++; $display("FAIL fresh_en_latency: got %0d expected %0d", en_rises[base] - acc, RST_PULSE + 2); end
        end
        vectors++; if (d !== 16'h2D00) begin miscompares++; $display("FAIL fresh_data: got %h expected 2d00", d); end
        vectors++; if (st !== 2'b00) begin miscompares++; $display("FAIL fresh_status: got %b expected 00", st); end
        vectors++; if (pv !== 1'b0) begin miscompares++; $display("FAIL fresh_valid_drop: got %b expected 0", pv); end
        model_store();
    endtask

    task automatic test_cached();
        int acc, vld, base, dly; logic [15:0] d; logic [1:0] st; logic pv, env; bit to; logic [1:0] sel;
        while (cyc < en_rises[$] + 200) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            new_sensor_values();
            sel = 2'($urandom_range(0, 2));
            dly = $urandom_range(0, 4) - 1;
            base = en_rises.size();
            do_req(sel, dly, acc, vld, d, st, pv, env, to);
            vectors++; if (to) begin miscompares++; $display("FAIL cached_done: got timeout expected response"); end
            vectors++; if (en_rises.size() !== base) begin miscompares++; $display("FAIL cached_no_en: got %0d pulses expected 0", en_rises.size() - base); end
            vectors++; if (vld - acc !== 2) begin miscompares++; $display("FAIL cached_latency: got %0d expected 2", vld - acc); end
            vectors++; if (d !== model_pick(sel, m_cache[0], m_cache[1], m_cache[2], m_cache[3])) begin miscompares++; $display("FAIL cached_data: got %h expected %h", d, model_pick(sel, m_cache[0], m_cache[1], m_cache[2], m_cache[3])); end
            vectors++; if (st !== 2'b01) begin miscompares++; $display("FAIL cached_status: got %b expected 01", st); end
            vectors++; if (pv !== 1'b0) begin miscompares++; $display("FAIL cached_valid_drop: got %b expected 0", pv); end
        end
    endtask

    task automatic test_backpressure();
        int n; logic [15:0] d0, exp_d; logic [1:0] s0; logic [1:0] sel;
        sel = 2'($urandom_range(0, 2));
        exp_d = model_pick(sel, m_cache[0], m_cache[1], m_cache[2], m_cache[3]);
        @(negedge clk);
        bus.req_sel = sel; bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
        n = 0;
        while (!bus.req_ready && n < LIMIT) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < LIMIT) begin @(negedge clk); n++; end
        vectors++; if (n >= LIMIT) begin miscompares++; $display("FAIL bp_done: got timeout expected response"); end
        d0 = bus.rsp_data; s0 = bus.rsp_status;
        vectors++; if (d0 !== exp_d || s0 !== 2'b01) begin miscompares++; $display("FAIL bp_first: got %h/%b expected %h/01", d0, s0, exp_d); end
        // A second request presented while the response is stalled
        bus.req_valid = 1'b1; bus.req_sel = 2'($urandom_range(0, 3));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0 || bus.rsp_status !== s0 || bus.req_ready !== 1'b0) begin
                miscompares++; $display("FAIL bp_stable[%0d]: got v=%b d=%h s=%b rdy=%b expected v=1 d=%h s=%b rdy=0", i, bus.rsp_valid, bus.rsp_data, bus.rsp_status, bus.req_ready, d0, s0);
            end
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        vectors++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got v=%b rdy=%b expected v=0 rdy=1", bus.rsp_valid, bus.req_ready); end
        repeat (5) @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL bp_ignored_req: got v=%b busy=%b expected 0/0", bus.rsp_valid, busy); end
        $display("txn sel=%0d status=%0d data=%04h stalled 20 cycles", sel, s0, d0);
    endtask

    task automatic test_failed_reads(input bit timeout_mode);
        int acc, vld, base; logic [15:0] d, exp_d; logic [1:0] st, exp_st; logic pv, env; bit to; logic [1:0] sel;
        wait_allowed();
        new_sensor_values();
        if (timeout_mode) drv_never_fall = 1'b1; else dht_crc = 1'b0;
        sel = 2'($urandom_range(0, 2));
        exp_d = m_cache_valid ? model_pick(sel, m_cache[0], m_cache[1], m_cache[2], m_cache[3]) : 16'h0;
        exp_st = timeout_mode ? 2'b11 : 2'b10;
        base = en_rises.size();
        do_req(sel, -1, acc, vld, d, st, pv, env, to);
        vectors++; if (to) begin miscompares++; $display("FAIL retry_done: got timeout expected response"); end
        vectors++; if (en_rises.size() - base !== RETRIES + 1) begin miscompares++; $display("FAIL retry_pulses: got %0d expected %0d", en_rises.size() - base, RETRIES + 1); end
        for (int i = base + 1; i < en_rises.size(); i++) begin
            vectors++; if (en_rises[i] - en_rises[i-1] < MIN_IV) begin miscompares++; $display("FAIL retry_spacing: got %0d expected >= %0d", en_rises[i] - en_rises[i-1], MIN_IV); end
        end
        if (timeout_mode) begin
            for (int i = en_widths.size() - (RETRIES + 1); i < en_widths.size(); i++) begin
                vectors++; if (i < 0 || en_widths[i] !== TIMEOUT) begin miscompares++; $display("FAIL timeout_en_width: got %0d expected %0d", (i < 0) ? -1 : en_widths[i], TIMEOUT); end
            end
        end
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL retry_status: got %b expected %b", st, exp_st); end
        vectors++; if (d !== exp_d) begin miscompares++; $display("FAIL retry_data: got %h expected %h", d, exp_d); end
        vectors++; if (env !== 1'b0) begin miscompares++; $display("FAIL retry_en_in_respond: got %b expected 0", env); end
        vectors++; if (pv !== 1'b0) begin miscompares++; $display("FAIL retry_ready_early: got %b expected 0", pv); end
        m_fail = (m_fail + RETRIES + 1 > 255) ? 255 : m_fail + RETRIES + 1;
        drv_never_fall = 1'b0; dht_crc = 1'b1;
        do_req(2'd3, 0, acc, vld, d, st, pv, env, to);
        vectors++; if (d !== {8'h00, 8'(m_fail)} || st !== 2'b00) begin miscompares++; $display("FAIL fail_count: got %h/%b expected %h/00", d, st, {8'h00, 8'(m_fail)}); end
    endtask

    task automatic test_reset_midread();
        int acc, vld, base, n; logic [15:0] d; logic [1:0] st; logic pv, env; bit to; logic [1:0] sel;
        wait_allowed();
        new_sensor_values();
        @(negedge clk);
        bus.req_sel = 2'($urandom_range(0, 2)); bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < LIMIT) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!dht_en && n < LIMIT) begin @(negedge clk); n++; end
        vectors++; if (n >= LIMIT) begin miscompares++; $display("FAIL midread_en: got no enable expected enable"); end
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (dht_en !== 1'b0 || dht_rst !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL midread_async: got en=%b rst=%b v=%b rdy=%b busy=%b expected 0 1 0 1 0", dht_en, dht_rst, bus.rsp_valid, bus.req_ready, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_cache_valid = 1'b0; m_fail = 0;
        do_req(2'd3, 0, acc, vld, d, st, pv, env, to);
        vectors++; if (d !== 16'h0000 || st !== 2'b00) begin miscompares++; $display("FAIL midread_failcount: got %h/%b expected 0000/00", d, st); end
        new_sensor_values();
        sel = 2'($urandom_range(0, 2));
        base = en_rises.size();
        do_req(sel, 1, acc, vld, d, st, pv, env, to);
        vectors++; if (en_rises.size() <= base || en_rises[base] - acc !== RST_PULSE + 2) begin miscompares++; $display("FAIL midread_fresh_start: got %0d pulses expected immediate read", en_rises.size() - base); end
        vectors++; if (d !== model_pick(sel, hum_int, hum_float, temp_int, temp_float) || st !== 2'b00) begin miscompares++; $display("FAIL midread_fresh: got %h/%b expected %h/00", d, st, model_pick(sel, hum_int, hum_float, temp_int, temp_float)); end
        model_store();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_sel   = 2'b00;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_fresh_read();
        test_cached();
        test_backpressure();
        test_failed_reads(1'b0);
        test_failed_reads(1'b1);
        test_reset_midread();
        vectors++; if (both_hi_seen) begin miscompares++; $display("FAIL en_rst_exclusive: got both high expected never"); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end
endmodule
